// File: rtl/rv32b_ise_pkg.sv
// Shared encodings, FSM/op enums and the instruction decoder for the
// rotate/and-not extension issue sequencer.
package rv32b_ise_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [2:0] F3_ROL  = 3'b001;
  localparam logic [2:0] F3_ROR  = 3'b101;
  localparam logic [2:0] F3_ANDN = 3'b111;

  localparam logic [6:0] F7_ROT  = 7'b0110000;
  localparam logic [6:0] F7_ANDN = 7'b0100000;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_ROT  = 1'b0,
    OP_ANDN = 1'b1
  } op_e;

  typedef struct packed {
    logic       ill;
    op_e        op;
    logic [4:0] amt;
  } dec_t;

  // Right rotates are folded into left rotates so the datapath needs one direction only.
  function automatic dec_t decode(
    input logic [6:0] opcode,
    input logic [2:0] funct3,
    input logic [6:0] funct7,
    input logic [4:0] shamt,
    input logic [4:0] rs2_amt
  );
    dec_t d;
    d.ill = 1'b0;
    d.op  = OP_ROT;
    d.amt = '0;
    if (opcode == OPC_OP && funct7 == F7_ROT && funct3 == F3_ROL) begin
      d.amt = rs2_amt;
    end else if (opcode == OPC_OP && funct7 == F7_ROT && funct3 == F3_ROR) begin
      d.amt = 5'd0 - rs2_amt;
    end else if (opcode == OPC_OPIMM && funct7 == F7_ROT && funct3 == F3_ROR) begin
      d.amt = 5'd0 - shamt;
    end else if (opcode == OPC_OP && funct7 == F7_ANDN && funct3 == F3_ANDN) begin
      d.op = OP_ANDN;
    end else begin
      d.ill = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/rv32b_ise_issue_dp.sv
// Combinational rotate/and-not datapath: five-stage left barrel rotator
// (1/2/4/8/16) and rs1 & ~rs2.
module rv32b_ise_dp
  import rv32b_ise_pkg::*;
(
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [4:0]  amt_i,
  input  op_e         op_i,
  output logic [31:0] res_o
);

  logic [31:0] s1, s2, s4, s8, s16;

  always_comb begin
    s1  = amt_i[0] ? {rs1_i[30:0], rs1_i[31]}    : rs1_i;
    s2  = amt_i[1] ? {s1[29:0],    s1[31:30]}    : s1;
    s4  = amt_i[2] ? {s2[27:0],    s2[31:28]}    : s2;
    s8  = amt_i[3] ? {s4[23:0],    s4[31:24]}    : s4;
    s16 = amt_i[4] ? {s8[15:0],    s8[31:16]}    : s8;
  end

  always_comb begin
    res_o = s16;
    if (op_i == OP_ANDN) begin
      res_o = rs1_i & ~rs2_i;
    end
  end

endmodule

// File: rtl/rv32b_ise_issue.sv
// Issue-side sequencer: decode on request accept, evaluate in EXEC,
// hold the registered result in RESP until the consumer takes it.
module rv32b_ise_issue
  import rv32b_ise_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_insn,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rd,
  output logic        rsp_illegal
);

  state_e      state_q, state_d;
  logic [31:0] rs1_q, rs2_q;
  logic [4:0]  amt_q;
  op_e         op_q;
  logic        ill_q;
  logic [31:0] rd_q, rd_d;
  logic        rsp_ill_q, rsp_ill_d;
  logic [31:0] dp_res;
  logic        accept, rsp_load;
  dec_t        dec;
  logic        unused_insn_bits;

  assign dec = decode(req_insn[6:0], req_insn[14:12], req_insn[31:25],
                      req_insn[24:20], req_rs2[4:0]);

  // Register-index fields are not needed here; writeback is the core's job.
  assign unused_insn_bits = ^{req_insn[19:15], req_insn[11:7]};

  rv32b_ise_dp u_dp (
    .rs1_i (rs1_q),
    .rs2_i (rs2_q),
    .amt_i (amt_q),
    .op_i  (op_q),
    .res_o (dp_res)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    rsp_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_load = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_d      = ill_q ? '0 : dp_res;
    rsp_ill_d = ill_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rs1_q     <= '0;
      rs2_q     <= '0;
      amt_q     <= '0;
      op_q      <= OP_ROT;
      ill_q     <= 1'b0;
      rd_q      <= '0;
      rsp_ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rs1_q <= req_rs1;
        rs2_q <= req_rs2;
        amt_q <= dec.amt;
        op_q  <= dec.op;
        ill_q <= dec.ill;
      end
      if (rsp_load) begin
        rd_q      <= rd_d;
        rsp_ill_q <= rsp_ill_d;
      end
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rd      = rd_q;
  assign rsp_illegal = rsp_ill_q;

endmodule

// File: tb/tb_rv32b_ise_issue.sv
// Scoreboard bench for rv32b_ise_issue: expectations queued at issue,
// compared when the response handshake is observed.
module tb_rv32b_ise_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_insn = '0;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rd;
  logic        rsp_illegal;

  int errors = 0;
  int checks = 0;
  int n_pushed = 0;
  int n_rsp = 0;
  logic [32:0] exp_q[$];

  rv32b_ise_issue dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_insn    (req_insn),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rd      (rsp_rd),
    .rsp_illegal (rsp_illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] a);
    logic [63:0] d;
    d = {x, x} << a;
    return d[63:32];
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] a);
    logic [63:0] d;
    d = {x, x} >> a;
    return d[31:0];
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_rori(input logic [4:0] sh);
    return {7'b0110000, sh, 5'd1, 3'b101, 5'd3, 7'b0010011};
  endfunction

  // {illegal, rd}
  function automatic logic [32:0] model(input logic [31:0] insn, input logic [31:0] rs1,
                                        input logic [31:0] rs2);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = insn[6:0];
    f3  = insn[14:12];
    f7  = insn[31:25];
    if (opc == 7'h33 && f3 == 3'd1 && f7 == 7'h30) return {1'b0, rotl(rs1, rs2[4:0])};
    if (opc == 7'h33 && f3 == 3'd5 && f7 == 7'h30) return {1'b0, rotr(rs1, rs2[4:0])};
    if (opc == 7'h13 && f3 == 3'd5 && f7 == 7'h30) return {1'b0, rotr(rs1, insn[24:20])};
    if (opc == 7'h33 && f3 == 3'd7 && f7 == 7'h20) return {1'b0, rs1 & ~rs2};
    return {1'b1, 32'h0};
  endfunction

  always @(negedge clk) begin : monitor
    logic [32:0] e;
    if (!rst && rsp_valid && rsp_ready) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_rsp", {31'b0, rsp_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("rsp_rd", rsp_rd, e[31:0]);
        check_eq("rsp_illegal", {31'b0, rsp_illegal}, {31'b0, e[32]});
      end
    end
  end

  task automatic send(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [32:0] exp, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_insn  = insn;
    req_rs1   = rs1;
    req_rs2   = rs2;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept", {31'b0, req_ready}, 32'd1);
    if (push) begin
      exp_q.push_back(exp);
      n_pushed++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Called right after send(); counts cycles from the accept cycle to rsp_valid.
  task automatic check_latency(input bit expect_ready_after);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      check_eq("ready_low_busy", {31'b0, req_ready}, 32'd0);
    end while (!rsp_valid && n < 20);
    check_eq("latency", n, 32'd2);
    if (expect_ready_after) begin
      @(negedge clk);
      check_eq("ready_after_hs", {31'b0, req_ready}, 32'd1);
      check_eq("valid_after_hs", {31'b0, rsp_valid}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    logic [31:0] held, insn, a, b;
    logic [32:0] e;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("reset_req_ready", {31'b0, req_ready}, 32'd1);
    check_eq("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("reset_rsp_rd", rsp_rd, 32'd0);
    check_eq("reset_rsp_illegal", {31'b0, rsp_illegal}, 32'd0);

    send(32'h60D55513, 32'h80000001, 32'h0, {1'b0, 32'h000C0000}, 1'b1);
    check_latency(1'b1);
    send(enc_r(7'h30, 3'd1), 32'h12345678, 32'd4, {1'b0, 32'h23456781}, 1'b1);
    check_latency(1'b1);
    send(enc_r(7'h30, 3'd5), 32'h12345678, 32'd4, {1'b0, 32'h81234567}, 1'b1);
    check_latency(1'b1);
    send(enc_r(7'h30, 3'd5), 32'h12345678, 32'h20, {1'b0, 32'h12345678}, 1'b1);
    check_latency(1'b1);
    send(enc_r(7'h20, 3'd7), 32'hFFFF0000, 32'h0F0F0F0F, {1'b0, 32'hF0F00000}, 1'b1);
    check_latency(1'b1);
    send(32'h00000033, 32'h12345678, 32'h11111111, {1'b1, 32'h0}, 1'b1);
    check_latency(1'b1);
    send(enc_rori(5'd0), 32'hDEADBEEF, 32'h0, {1'b0, 32'hDEADBEEF}, 1'b1);
    check_latency(1'b1);
    send(enc_rori(5'd31), 32'h80000001, 32'h0, {1'b0, 32'h00000003}, 1'b1);
    check_latency(1'b1);

    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: insn = enc_r(7'h30, 3'd1);
        1: insn = enc_r(7'h30, 3'd5);
        2: insn = enc_rori(5'($urandom_range(0, 31)));
        3: insn = enc_r(7'h20, 3'd7);
        default: insn = $urandom;
      endcase
      e = model(insn, a, b);
      send(insn, a, b, e, 1'b1);
      check_latency(1'b0);
    end
    repeat (2) @(negedge clk);

    // Backpressure with a second request waiting behind the stalled response.
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    send(enc_r(7'h20, 3'd7), 32'hFFFF0000, 32'h0F0F0F0F, {1'b0, 32'hF0F00000}, 1'b1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("bp_valid_rise", {31'b0, rsp_valid}, 32'd1);
    held = rsp_rd;
    req_valid = 1'b1;
    req_insn  = enc_r(7'h30, 3'd1);
    req_rs1   = 32'h12345678;
    req_rs2   = 32'd4;
    repeat (5) begin
      @(negedge clk);
      check_eq("bp_valid_hold", {31'b0, rsp_valid}, 32'd1);
      check_eq("bp_rd_stable", rsp_rd, held);
      check_eq("bp_no_accept", {31'b0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("bp_accept_after_hs", n, 32'd1);
    exp_q.push_back({1'b0, 32'h23456781});
    n_pushed++;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check_latency(1'b1);

    // Reset while the instruction sits in EXEC.
    send(enc_r(7'h30, 3'd5), 32'hCAFEF00D, 32'd8, {1'b0, 32'h0}, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rstexec_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rstexec_rsp_rd", rsp_rd, 32'd0);
    check_eq("rstexec_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (8) begin
      @(negedge clk);
      check_eq("rstexec_no_stale", {31'b0, rsp_valid}, 32'd0);
    end

    send(enc_rori(5'd13), 32'h80000001, 32'h0, {1'b0, 32'h000C0000}, 1'b1);
    check_latency(1'b1);

    repeat (4) @(negedge clk);
    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check_eq("rsp_count", n_rsp, n_pushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
